// File: rtl/adc_spi_sequencer_if.sv
// Handshake and serial-link signals between the ADC sequencer and its user/ADC.
// master = requester plus ADC side (drives start/continuo/sdata); slave = the sequencer.
interface adc_spi_sequencer_if #(
    parameter int unsigned DATA_W = 12
);
    logic              start;
    logic              continuo;
    logic              sdata;
    logic              cs_n;
    logic              sclk;
    logic [DATA_W-1:0] dato;
    logic              dato_valido;
    logic              ocupado;

    modport master (
        output start,
        output continuo,
        output sdata,
        input  cs_n,
        input  sclk,
        input  dato,
        input  dato_valido,
        input  ocupado
    );

    modport slave (
        input  start,
        input  continuo,
        input  sdata,
        output cs_n,
        output sclk,
        output dato,
        output dato_valido,
        output ocupado
    );
endinterface

// File: rtl/adc_spi_sequencer.sv
// Frame sequencer for a 16-SCLK serial ADC: generates CS_n/SCLK from a half-period
// counter, shifts in the frame and presents a DATA_W-bit sample with a valid strobe.
module adc_spi_sequencer #(
    parameter int unsigned HALF_PERIOD = 70,
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned DATA_W      = 12
) (
    input logic                Clck_in,
    input logic                reset_Clock,
    adc_spi_sequencer_if.slave bus_io
);

    localparam int unsigned CntW = (HALF_PERIOD > 0) ? $clog2(HALF_PERIOD + 1) : 1;
    localparam int unsigned BitW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CntW-1:0] HpMax   = CntW'(HALF_PERIOD);
    localparam logic [BitW-1:0] LastBit = BitW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StDone,
        StQuiet
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   hp_cnt_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              quiet_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic [DATA_W-1:0] dato_q;
    logic              valid_q;
    logic              busy_q;
    logic              tick;

    assign tick = (state_q != StIdle) && (hp_cnt_q == HpMax);

    always_ff @(posedge Clck_in) begin
        if (reset_Clock) begin
            state_q   <= StIdle;
            hp_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            quiet_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            dato_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (state_q == StIdle || tick) begin
                hp_cnt_q <= '0;
            end else begin
                hp_cnt_q <= hp_cnt_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (bus_io.start || bus_io.continuo) begin
                        state_q <= StSetup;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        // Only the last DATA_W bits are kept; leading frame bits fall off the top.
                        if (!sclk_q) begin
                            shift_q   <= {shift_q[DATA_W-2:0], bus_io.sdata};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LastBit) begin
                                state_q <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    if (tick) begin
                        cs_n_q  <= 1'b1;
                        dato_q  <= shift_q;
                        valid_q <= 1'b1;
                        quiet_q <= 1'b0;
                        state_q <= StQuiet;
                    end
                end
                StQuiet: begin
                    if (tick) begin
                        if (!quiet_q) begin
                            quiet_q <= 1'b1;
                        end else if (bus_io.continuo) begin
                            state_q <= StSetup;
                            cs_n_q  <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.cs_n        = cs_n_q;
    assign bus_io.sclk        = sclk_q;
    assign bus_io.dato        = dato_q;
    assign bus_io.dato_valido = valid_q;
    assign bus_io.ocupado     = busy_q;

endmodule
